// File: rtl/mul32_sequencer.sv
// Multi-cycle 32x32->32 truncated multiplier built around one shared 16x16 multiplier.
// Three partial-product cycles (lo*lo, hi*lo, lo*hi) feed an accumulator; done pulses in DONE.
module mul32_sequencer #(
  parameter int DW = 32,
  parameter int HW = DW / 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          flush_i,
  input  logic [DW-1:0] din_a_i,
  input  logic [DW-1:0] din_b_i,
  output logic          stall_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] dout_o,
  output logic          cout_o,
  output logic          vout_o
);

  typedef enum logic [2:0] {S_IDLE, S_PP0, S_PP1, S_PP2, S_DONE} state_t;

  state_t        state_q;
  logic [DW-1:0] a_q, b_q, acc_q, dout_q;
  logic          cout_q, vout_q;

  logic          accept, in_pp;
  logic [HW-1:0] mul_x, mul_y;
  logic [DW-1:0] prod, acc_d;
  logic          vout_d;

  assign accept = start_i & ~flush_i & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign in_pp  = (state_q == S_PP0) | (state_q == S_PP1) | (state_q == S_PP2);

  // Operand steering into the single shared multiplier
  always_comb begin
    mul_x = a_q[HW-1:0];
    mul_y = b_q[HW-1:0];
    case (state_q)
      S_PP1:   mul_x = a_q[DW-1:HW];
      S_PP2:   mul_y = b_q[DW-1:HW];
      default: ;
    endcase
  end

  assign prod   = {{HW{1'b0}}, mul_x} * {{HW{1'b0}}, mul_y};
  // Cross terms only contribute their low half, shifted into the upper half of the result
  assign acc_d  = (state_q == S_PP0) ? prod : acc_q + {prod[HW-1:0], {HW{1'b0}}};
  assign vout_d = ~(a_q[DW-1] ^ b_q[DW-1] ^ acc_d[DW-1]);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
      vout_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q     <= din_a_i;
            b_q     <= din_b_i;
            state_q <= S_PP0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PP0: begin
          acc_q   <= acc_d;
          state_q <= S_PP1;
        end
        S_PP1: begin
          acc_q   <= acc_d;
          state_q <= S_PP2;
        end
        S_PP2: begin
          acc_q   <= acc_d;
          dout_q  <= acc_d;
          cout_q  <= 1'b0;
          vout_q  <= vout_d;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o = accept | in_pp;
  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign dout_o  = dout_q;
  assign cout_o  = cout_q;
  assign vout_o  = vout_q;

endmodule

// File: tb/tb_mul32_sequencer.sv
// Bench for mul32_sequencer: directed cases with literal results, then random traffic
// compared every cycle against an operation-level model (in-flight countdown + a*b).
module tb_mul32_sequencer;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [31:0] din_a = '0, din_b = '0;
  logic        stall, busy, done, cout, vout;
  logic [31:0] dout;

  int checks = 0, errors = 0;

  mul32_sequencer dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .flush_i(flush),
    .din_a_i(din_a), .din_b_i(din_b),
    .stall_o(stall), .busy_o(busy), .done_o(done),
    .dout_o(dout), .cout_o(cout), .vout_o(vout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_rem = cycles of work left for the operation in flight (0 = none)
  int          m_rem = 0, n_acc = 0, n_done = 0;
  logic        m_done = 1'b0, m_vout = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_dout = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_done = 1'b0; m_dout = '0; m_vout = 1'b0;
    end else if (flush) begin
      m_rem = 0; m_done = 1'b0;
    end else if (start && m_rem == 0) begin
      m_a = din_a; m_b = din_b; m_rem = 3; m_done = 1'b0; n_acc++;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_dout = m_a * m_b;
        m_vout = ~(m_a[31] ^ m_b[31] ^ m_dout[31]);
        n_done++;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  int run_len = 0, run_base = 0;

  always @(negedge clk) begin
    chk("done",  {31'b0, done},  {31'b0, m_done});
    chk("busy",  {31'b0, busy},  {31'b0, (m_rem > 0) || m_done});
    chk("stall", {31'b0, stall}, {31'b0, (start && !flush && m_rem == 0) || (m_rem > 0)});
    chk("dout",  dout, m_dout);
    chk("vout",  {31'b0, vout},  {31'b0, m_vout});
    chk("cout",  {31'b0, cout},  32'd0);
    if (busy) begin
      run_len++;
      chk("busy_run", {31'b0, run_len <= 4 * (n_acc - run_base)}, 32'd1);
    end else begin
      run_len  = 0;
      run_base = n_acc;
    end
  end

  // Called at a negedge; pulses start for one cycle, returns at the negedge where done is seen.
  task automatic op(input logic [31:0] a, input logic [31:0] b, output int lat);
    #1 start = 1'b1; din_a = a; din_b = b; lat = 0;
    while (lat < 10) begin
      @(negedge clk); lat++;
      if (done) break;
      #1 start = 1'b0; din_a = $urandom; din_b = $urandom;
    end
    start = 1'b0;
  endtask

  int lat;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    #1 reset = 1'b0;
    @(negedge clk);

    op(32'd3, 32'd5, lat);
    chk("t1_lat", lat, 32'd4);
    chk("t1_dout", dout, 32'h0000000F);
    chk("t1_cout", {31'b0, cout}, 32'd0);

    op(32'h12345678, 32'h9ABCDEF0, lat);
    chk("t2_lat", lat, 32'd4);
    chk("t2_dout", dout, 32'h242D2080);
    chk("t2_vout", {31'b0, vout}, 32'd0);
    chk("t2_model", m_dout, 32'h242D2080);

    op(32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("t3_dout", dout, 32'h00000001);
    chk("t3_vout", {31'b0, vout}, 32'd1);
    op(32'd7, 32'd6, lat);
    chk("t3_b2b_lat", lat, 32'd4);
    chk("t3_b2b_dout", dout, 32'h0000002A);

    // Flush in PP1
    #1 start = 1'b1; din_a = 32'd2; din_b = 32'd2;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_stall", {31'b0, stall}, 32'd0);
    chk("t4_dout", dout, 32'h0000002A);
    #1 flush = 1'b0;
    repeat (5) @(negedge clk);

    // start+flush together, then reset during PP2
    #1 start = 1'b1; flush = 1'b1;
    @(negedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    #1 start = 1'b1; din_a = 32'd9; din_b = 32'd9;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_dout", dout, 32'd0);
    chk("t5_done", {31'b0, done}, 32'd0);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);

    // Random traffic until 1000 completions
    begin
      int base = n_done;
      for (int c = 0; c < 30000 && (n_done - base) < 1000; c++) begin
        #1 start = ($urandom % 3) != 0;
        flush = ($urandom % 20) == 0;
        din_a = $urandom; din_b = $urandom;
        @(negedge clk);
      end
      #1 start = 1'b0; flush = 1'b0;
      chk("rand_ops", {31'b0, (n_done - base) >= 1000}, 32'd1);
    end
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
